// File: rtl/io_pkg.sv
// Shared types and helpers for the I/O port bank: channel FSM states,
// the port-count ceiling and an elaboration-time log2 helper.
package io_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_PEND = 1'b1
    } port_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_port_chan.sv
// One I/O channel: output word register with a valid/ready handshake FSM,
// plus a two-flop synchroniser for the matching external input word.
module io_port_chan
    import io_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pready,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             busy,
    output logic [WIDTH-1:0] pin_sync
);

    // Handshake: a word moves on any rising edge with pvalid && pready.
    // wr_en is only raised by the parent when busy is low, so a write in
    // PEND always coincides with the consumer taking the old word.
    port_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PORT_IDLE;
            data_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sync1_q <= pin;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            PORT_IDLE: begin
                if (wr_en) begin
                    data_d  = wdata;
                    state_d = PORT_PEND;
                end
            end
            PORT_PEND: begin
                if (wr_en) begin
                    data_d = wdata;
                end else if (pready) begin
                    state_d = PORT_IDLE;
                end
            end
            default: state_d = PORT_IDLE;
        endcase
    end

    assign pvalid   = (state_q == PORT_PEND);
    assign busy     = pvalid && !pready;
    assign pout     = data_q;
    assign pin_sync = sync2_q;

endmodule

// File: rtl/io_port_bank.sv
// CPU-facing bank of NPORTS handshaked output channels and synchronised
// input channels, selected by a shared address for writes and reads.
module io_port_bank
    import io_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  NPORTS = 4,
    localparam int AW     = (clog2(NPORTS) > 1) ? clog2(NPORTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic                    re,
    input  logic [AW-1:0]           addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    stall,
    output logic [NPORTS*WIDTH-1:0] pout,
    output logic [NPORTS-1:0]       pvalid,
    input  logic [NPORTS-1:0]       pready,
    input  logic [NPORTS*WIDTH-1:0] pin
);

    logic [NPORTS-1:0]             sel;
    logic [NPORTS-1:0]             busy;
    logic [NPORTS-1:0]             wr_en;
    logic [NPORTS-1:0][WIDTH-1:0]  sync_arr;
    logic [WIDTH-1:0]              rd_mux;
    logic [WIDTH-1:0]              rdata_q, rdata_d;

    // One-hot decode; addresses at or above NPORTS select nothing, so they
    // neither write, stall nor return anything but zero.
    always_comb begin
        sel    = '0;
        rd_mux = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (addr == AW'(i)) begin
                sel[i] = 1'b1;
                rd_mux = sync_arr[i];
            end
        end
    end

    assign stall = we && |(sel & busy);
    assign wr_en = {NPORTS{we}} & sel & ~busy;

    for (genvar g = 0; g < NPORTS; g++) begin : g_chan
        io_port_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[g]),
            .wdata   (wdata),
            .pready  (pready[g]),
            .pin     (pin[g*WIDTH +: WIDTH]),
            .pout    (pout[g*WIDTH +: WIDTH]),
            .pvalid  (pvalid[g]),
            .busy    (busy[g]),
            .pin_sync(sync_arr[g])
        );
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed scenarios plus a randomised run on a
// 16x4 instance against a transaction-level model, and small 16x3 / 8x1 instances.
module tb_io_port_bank;

  localparam int W  = 16;
  localparam int NP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 16-bit, 4-channel instance
  logic            we, re;
  logic [1:0]      addr;
  logic [W-1:0]    wdata, rdata;
  logic            stall;
  logic [NP*W-1:0] pout, pin;
  logic [NP-1:0]   pvalid, pready;

  io_port_bank #(.WIDTH(W), .NPORTS(NP)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .pout(pout), .pvalid(pvalid),
    .pready(pready), .pin(pin)
  );

  // 16-bit, 3-channel instance
  logic         we3, re3;
  logic [1:0]   addr3;
  logic [15:0]  wdata3, rdata3;
  logic         stall3;
  logic [47:0]  pout3, pin3;
  logic [2:0]   pvalid3, pready3;

  io_port_bank #(.WIDTH(16), .NPORTS(3)) dut3 (
    .clk(clk), .reset(reset), .we(we3), .re(re3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .stall(stall3), .pout(pout3), .pvalid(pvalid3),
    .pready(pready3), .pin(pin3)
  );

  // 8-bit, 1-channel instance with pout looped back to pin
  logic        we1, re1;
  logic [0:0]  addr1;
  logic [7:0]  wdata1, rdata1, pout1, pin1;
  logic        stall1;
  logic [0:0]  pvalid1, pready1;

  assign pin1 = pout1;

  io_port_bank #(.WIDTH(8), .NPORTS(1)) dut1 (
    .clk(clk), .reset(reset), .we(we1), .re(re1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .stall(stall1), .pout(pout1), .pvalid(pvalid1),
    .pready(pready1), .pin(pin1)
  );

  // Reference model: channel contents, read register, and pin history
  // (rdata sampled at edge k reflects the pin word seen at edge k-2).
  logic [W-1:0]    m_data [NP];
  logic [NP-1:0]   m_valid;
  logic [W-1:0]    m_rdata;
  logic [NP*W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_data[i] = '0;
    m_valid = '0;
    m_rdata = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  function automatic logic exp_stall();
    return we && m_valid[addr] && !pready[addr];
  endfunction

  task automatic model_edge();
    logic [NP*W-1:0] pin_old;
    logic            take, wr;
    pin_old = exp_q.pop_front();
    exp_q.push_back(pin);
    if (re) m_rdata = pin_old[addr*W +: W];
    for (int i = 0; i < NP; i++) begin
      take = m_valid[i] && pready[i];
      wr   = we && (addr == i) && (!m_valid[i] || pready[i]);
      if (wr) begin
        m_data[i]  = wdata;
        m_valid[i] = 1'b1;
      end else if (take) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NP*W-1:0] ep;
    for (int i = 0; i < NP; i++) ep[i*W +: W] = m_data[i];
    check({tag, "_pout"}, pout, ep);
    check({tag, "_pvalid"}, pvalid, m_valid);
    check({tag, "_rdata"}, rdata, m_rdata);
  endtask

  // Inputs are driven at the falling edge; stall is sampled 1 ns later,
  // registered outputs at the next falling edge.
  task automatic tick(input string tag);
    #1 check({tag, "_stall"}, stall, exp_stall());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic edge_only();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    we = 0; re = 0; addr = 0; wdata = 0; pready = 0; pin = 0;
    we3 = 0; re3 = 0; addr3 = 0; wdata3 = 0; pready3 = 0; pin3 = 0;
    we1 = 0; re1 = 0; addr1 = 0; wdata1 = 0; pready1 = 0;
    model_reset();

    #1 reset = 1'b0;
    #2;
    check("por_pout", pout, 64'h0);
    check("por_pvalid", pvalid, 4'h0);
    check("por_rdata", rdata, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single write and its consumption
    we = 1; addr = 2; wdata = 16'hBEEF; pready = 0;
    tick("wr1");
    we = 0;
    check("wr1_valid", pvalid, 4'b0100);
    check("wr1_data", pout[47:32], 16'hBEEF);
    pready = 4'b0100;
    tick("take1");
    pready = 0;
    check("take1_valid", pvalid[2], 1'b0);

    // Stall while the consumer is not ready
    we = 1; addr = 2; wdata = 16'hBEEF;
    tick("prefill");
    wdata = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_hold", stall, 1'b1);
      tick("stall_cyc");
    end
    pready = 4'b0100;
    #1 check("stall_release", stall, 1'b0);
    tick("stall_acc");
    we = 0; pready = 0;
    check("stall_data", pout[47:32], 16'h1234);
    check("stall_valid", pvalid[2], 1'b1);
    pready = 4'hF;
    tick("drain");
    pready = 0;

    // Back-to-back writes to distinct channels
    for (int k = 0; k < 4; k++) begin
      we = 1; addr = k[1:0]; wdata = 16'(k + 1);
      #1 check("par_stall", stall, 1'b0);
      tick("par");
    end
    we = 0;
    check("par_valid", pvalid, 4'hF);
    check("par_data", pout, 64'h0004_0003_0002_0001);
    pready = 4'hF;
    tick("par_drain");
    pready = 0;

    // Input synchroniser plus read register
    pin[63:48] = 16'hA5A5;
    re = 1; addr = 3;
    tick("rd1");
    check("rd_early1", rdata, 16'h0);
    tick("rd2");
    check("rd_early2", rdata, 16'h0);
    tick("rd3");
    check("rd_late", rdata, 16'hA5A5);
    re = 0;

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom_range(0, 1));
      re     = 1'($urandom_range(0, 1));
      addr   = 2'($urandom_range(0, 3));
      wdata  = 16'($urandom);
      pready = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pin = {$urandom, $urandom};
      tick("rnd");
    end

    // Asynchronous reset with a word pending on channel 1
    we = 0; re = 0; pready = 4'hF;
    tick("flush");
    pready = 0;
    pin = 64'h4444_3333_2222_1111;
    re = 1; addr = 0;
    tick("pre1");
    we = 1; addr = 1; wdata = 16'hCAFE; re = 0;
    tick("pre2");
    re = 1; addr = 0; we = 0;
    tick("pre3");
    check("pre_valid1", pvalid[1], 1'b1);
    check("pre_rdata", rdata, 16'h1111);
    we = 1; addr = 1; re = 0;
    #2 reset = 1'b0;
    #1;
    check("arst_pout", pout, 64'h0);
    check("arst_pvalid", pvalid, 4'h0);
    check("arst_rdata", rdata, 16'h0);
    check("arst_stall", stall, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    we = 0; re = 1; addr = 3;
    tick("post1");
    tick("post2");
    tick("post3");
    re = 0;

    // 3-channel instance: out-of-range address
    pin3[15:0] = 16'h3C3C;
    re3 = 1; addr3 = 0;
    edge_only(); edge_only(); edge_only();
    check("n3_rd0", rdata3, 16'h3C3C);
    addr3 = 3; we3 = 1; wdata3 = 16'hFFFF;
    #1 check("n3_stall", stall3, 1'b0);
    edge_only();
    we3 = 0; re3 = 0;
    check("n3_rd3", rdata3, 16'h0);
    check("n3_pvalid", pvalid3, 3'b000);
    check("n3_pout", pout3, 48'h0);

    // 1-channel, 8-bit instance with loopback
    we1 = 1; addr1 = 0; wdata1 = 8'h7F; pready1 = 0;
    edge_only();
    we1 = 0;
    check("n1_valid", pvalid1, 1'b1);
    check("n1_pout", pout1, 8'h7F);
    re1 = 1;
    edge_only(); edge_only(); edge_only();
    check("n1_loop", rdata1, 8'h7F);
    we1 = 1; addr1 = 1; wdata1 = 8'h55;
    #1 check("n1_oor_stall", stall1, 1'b0);
    edge_only();
    we1 = 0; re1 = 0;
    check("n1_oor_pout", pout1, 8'h7F);
    check("n1_oor_valid", pvalid1, 1'b1);
    check("n1_oor_rdata", rdata1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised CPU I/O port unit replacing the fixed four 16-bit output ports of the current `cpu`. It exposes NPORTS output channels, each with a valid/ready handshake, and NPORTS synchronised input channels. All are addressed over a single-cycle CPU write/read strobe interface. The CPU stalls only when it writes a channel whose previous word has not yet been consumed.

## Interface
- WIDTH, 16: data width of every port.
- NPORTS, 4: number of output and input channels. Legal range 1..16.
- AW, derived localparam = max(1, clog2(NPORTS)): address width. Not overridable.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- we  in  1  CPU write strobe, one word per accepted cycle.
- re  in  1  CPU read strobe.
- addr  in  AW  channel select for both we and re.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  registered read data.
- stall  out  1  combinational; write not accepted this cycle, CPU must hold we/addr/wdata.
- pout  out  NPORTS*WIDTH  output channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- pvalid  out  NPORTS  output channel i holds an unconsumed word.
- pready  in  NPORTS  consumer of channel i accepts the word.
- pin  in  NPORTS*WIDTH  asynchronous external input channels, same packing as pout.

## Operation
- Each output channel runs a 2-state FSM: IDLE (pvalid=0) and PEND (pvalid=1).
- Transfer: a word on channel i is consumed on any rising edge where pvalid[i] && pready[i].
- Write to channel i in IDLE (addr < NPORTS): accepted. pout[i] <= wdata, go to PEND.
- Write to channel i in PEND with pready[i]=1: accepted in the same edge as the transfer. pout[i] <= wdata, stay in PEND. The old word is consumed and the new word is presented from the next cycle.
- Write to channel i in PEND with pready[i]=0: stall=1, no state change.
- In PEND with pready[i]=1 and no accepted write to i: go to IDLE. pout[i] holds its last value.
- stall = we && addr<NPORTS && state[addr]==PEND && !pready[addr]. It depends only on the current state and inputs.
- addr >= NPORTS: writes are ignored and never stall. Reads return 0.
- Input path: each pin channel passes through a 2-flop synchroniser (whole word; the producer holds data stable for at least 3 cycles).
- Read: when re=1, rdata <= sync2[addr] on the edge; otherwise rdata holds.
- we and re in the same cycle are independent and both serviced.
- Reset (async assert, any time including mid-PEND): all channels go to IDLE, pout=0, pvalid=0, rdata=0, synchroniser flops=0, stall=0. Pending words are discarded.

## Timing
- Write latency: pout/pvalid update on the edge that accepts the write and are visible in the following cycle.
- Back-to-back writes to different channels: one per cycle, no stall.
- Back-to-back writes to one channel: the second write stalls until pready is high in the same cycle.
- Maximum sustained rate is one word per cycle per channel while pready is held high.
- Read latency: 1 cycle from the re edge to rdata.
- Pin-to-rdata: at most 3 edges (2 synchroniser edges plus the read register).
- No combinational path from pready to pvalid/pout. The only combinational path is pready to stall.

## Structure
- Package `io_pkg`:
  - port_state_t enum {PORT_IDLE, PORT_PEND};
  - function clog2;
  - MAX_PORTS = 16.
- Sub-module `io_port_chan`: one output FSM plus data register and one input synchroniser. Parameter WIDTH. Ports: clk, reset, wr_en, wdata, pready, pin, pout, pvalid, busy, pin_sync.
- Top level: generate-loop of NPORTS `io_port_chan` instances, address decode, stall mux, rdata register.

## Test plan
- Reset: WIDTH=16, NPORTS=4, reset low mid-run with pvalid[1]=1. Required: pout=0, pvalid=0, rdata=0, stall=0 immediately, independent of clk.
- Single write: we, addr=2, wdata=16'hBEEF, pready=0. Required next cycle: pvalid=4'b0100, pout[47:32]=16'hBEEF. Raise pready[2] for one cycle; pvalid[2]=0 after that edge.
- Stall: with channel 2 in PEND and pready[2]=0, write 16'h1234 to addr 2. Required: stall=1 each cycle. When pready[2]=1: stall=0 in the same cycle, pout[47:32]=16'h1234 and pvalid[2]=1 next cycle.
- Parallel channels: writes of 16'h0001..16'h0004 to addr 0..3 on four consecutive cycles, pready=0. Required: no stall, pvalid=4'hF, each slice correct.
- Read: set pin channel 3 to 16'hA5A5, issue re, addr=3 on every cycle. Required: rdata=16'hA5A5 within 3 edges, earlier value before that. A read of addr 3 with NPORTS=3 returns 0.
- Parametrisation: WIDTH=8, NPORTS=1 (AW=1). Write 8'h7F to addr 0 and read it back via pin loopback. A write to addr 1 is ignored with stall=0.
